// File: rtl/pcileech_com_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_com_pkg
// Shared definitions for the PCILeech communication receive packer:
//   com_rxpack_state_t : boot / run state of the packer front end
//   COM_SYNC_WORD      : default resync marker on the transport stream
//   COM_DW_IN          : default transport word width
//   com_sat_inc16      : saturating 16-bit increment for event counters
// ---------------------------------------------------------------------------
package pcileech_com_pkg;

    typedef enum logic [1:0] {
        INIT_WAIT = 2'd0,
        INIT_SEND = 2'd1,
        RUN       = 2'd2
    } com_rxpack_state_t;

    localparam logic [31:0] COM_SYNC_WORD = 32'h66665555;
    localparam int          COM_DW_IN     = 32;

    function automatic logic [15:0] com_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcileech_com_rxpack_fifo.sv
// ---------------------------------------------------------------------------
// pcileech_com_rxpack_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_en consumes it.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears pointers)
//   wr_en     : write wr_data (caller guarantees !full or a same-cycle read)
//   rd_en     : pop head (caller guarantees !empty)
//   rd_data   : head entry
//   full      : DEPTH entries stored
//   empty     : no entries stored
// ---------------------------------------------------------------------------
module pcileech_com_rxpack_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/pcileech_com_rxpack.sv
// ---------------------------------------------------------------------------
// pcileech_com_rxpack
// Packs RATIO transport words of DW_IN bits into one DW_IN*RATIO command
// word (earliest word in the MSBs), supports host-driven lane resync via
// two consecutive SYNC words, injects INIT_CNT on-board command words after
// INIT_DELAY cycles from reset, and buffers packed words in an FWFT FIFO.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   init_data    : static boot words, word 0 in the LSBs
//   in_data      : transport word, qualified by in_valid (no backpressure)
//   out_data     : injected or packed word, qualified by out_valid
//   out_ready    : consumer accept
//   sync_event   : one-cycle pulse after a resync
//   init_done    : high once boot injection has finished
//   overflow_cnt : saturating count of packed words dropped on a full FIFO
// ---------------------------------------------------------------------------
module pcileech_com_rxpack
    import pcileech_com_pkg::*;
#(
    parameter int          DW_IN      = COM_DW_IN,
    parameter int          RATIO      = 2,
    parameter logic [31:0] SYNC_WORD  = COM_SYNC_WORD,
    parameter int          INIT_CNT   = 5,
    parameter int          INIT_DELAY = 16,
    parameter int          FIFO_DEPTH = 4,
    localparam int         DW_OUT     = DW_IN * RATIO,
    // A zero-word boot table still needs a non-empty port.
    localparam int         INIT_N     = (INIT_CNT > 0) ? INIT_CNT : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INIT_N*DW_OUT-1:0] init_data,
    input  logic [DW_IN-1:0]         in_data,
    input  logic                     in_valid,
    output logic [DW_OUT-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sync_event,
    output logic                     init_done,
    output logic [15:0]              overflow_cnt
);

    localparam int PACK_W = DW_OUT - DW_IN;
    localparam int LANE_W = $clog2(RATIO);
    localparam int IDX_W  = (INIT_N > 1) ? $clog2(INIT_N) : 1;
    localparam int DLY_W  = $clog2(INIT_DELAY + 2);

    localparam logic [DW_IN-1:0]  SYNC_W    = DW_IN'(SYNC_WORD);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INIT_N - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);

    // ------------------------------------------------------------------
    // Packing datapath
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane_q,      lane_d;
    logic [PACK_W-1:0] pack_q,      pack_d;
    logic [DW_IN-1:0]  last_word_q, last_word_d;
    logic              sync_event_q;
    logic [15:0]       overflow_cnt_q;

    logic              sync_hit;
    logic              accept;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DW_OUT-1:0] fifo_head;
    logic [DW_OUT-1:0] packed_word;

    com_rxpack_state_t state_q;
    logic [DLY_W-1:0]  dly_q;
    logic [IDX_W-1:0]  idx_q;
    logic              init_done_q;
    logic [DW_OUT-1:0] init_word;

    // A resync needs two SYNC words in a row; the second one is swallowed
    // and leaves last_word untouched, so a run of SYNC words keeps resyncing.
    assign sync_hit    = in_valid && (in_data == SYNC_W) && (last_word_q == SYNC_W);
    assign accept      = in_valid && !sync_hit;
    assign push        = accept && (lane_q == LANE_LAST);
    assign packed_word = {pack_q, in_data};
    assign pop         = (state_q == RUN) && !fifo_empty && out_ready;
    // A full FIFO still takes the push when its head leaves this cycle.
    assign push_ok     = push && (!fifo_full || pop);

    always_comb begin
        lane_d      = lane_q;
        pack_d      = pack_q;
        last_word_d = last_word_q;
        if (sync_hit) begin
            lane_d = '0;
            pack_d = '0;
        end else if (accept) begin
            last_word_d = in_data;
            if (lane_q == LANE_LAST) begin
                lane_d = '0;
            end else begin
                // Shift left so the earliest lane ends up in the MSBs.
                pack_d = PACK_W'({pack_q, in_data});
                lane_d = lane_q + LANE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q         <= '0;
            pack_q         <= '0;
            last_word_q    <= '0;
            sync_event_q   <= 1'b0;
            overflow_cnt_q <= '0;
        end else begin
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            last_word_q  <= last_word_d;
            sync_event_q <= sync_hit;
            if (push && !push_ok) overflow_cnt_q <= com_sat_inc16(overflow_cnt_q);
        end
    end

    pcileech_com_rxpack_fifo #(
        .DW    (DW_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_data (packed_word),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Boot injection state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_WAIT;
            dly_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                INIT_WAIT: begin
                    if (dly_q == DLY_LAST) begin
                        dly_q <= '0;
                        if (INIT_CNT == 0) begin
                            state_q     <= RUN;
                            init_done_q <= 1'b1;
                        end else begin
                            state_q <= INIT_SEND;
                        end
                    end else begin
                        dly_q <= dly_q + DLY_ONE;
                    end
                end
                INIT_SEND: begin
                    if (out_ready) begin
                        if (idx_q == IDX_LAST) begin
                            state_q     <= RUN;
                            init_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= INIT_WAIT;
                end
            endcase
        end
    end

    always_comb begin
        init_word = '0;
        for (int i = 0; i < INIT_N; i++) begin
            if (idx_q == IDX_W'(i)) init_word = init_data[i*DW_OUT +: DW_OUT];
        end
    end

    // ------------------------------------------------------------------
    // Output select: decoded from registered state, idx and FIFO pointers,
    // so the word holds steady until the consumer takes it.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        unique case (state_q)
            INIT_SEND: begin
                out_valid = 1'b1;
                out_data  = init_word;
            end
            RUN: begin
                out_valid = !fifo_empty;
                out_data  = fifo_empty ? '0 : fifo_head;
            end
            default: begin
                out_valid = 1'b0;
                out_data  = '0;
            end
        endcase
    end

    assign sync_event   = sync_event_q;
    assign init_done    = init_done_q;
    assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_pcileech_com_rxpack.sv
// ---------------------------------------------------------------------------
// tb_pcileech_com_rxpack
// Directed bench for pcileech_com_rxpack: a default instance (RATIO=2,
// INIT_CNT=5) and a wide instance (RATIO=4, INIT_CNT=0).
// ---------------------------------------------------------------------------
module tb_pcileech_com_rxpack;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic         rst;
    logic [319:0] init_data;
    logic [31:0]  in_data;
    logic         in_valid;
    logic [63:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         sync_event;
    logic         init_done;
    logic [15:0]  overflow_cnt;

    // Wide instance
    logic         rst4;
    logic [127:0] init_data4;
    logic [31:0]  in_data4;
    logic         in_valid4;
    logic [127:0] out_data4;
    logic         out_valid4;
    logic         out_ready4;
    logic         sync_event4;
    logic         init_done4;
    logic [15:0]  overflow_cnt4;

    int checks = 0;
    int errors = 0;

    pcileech_com_rxpack dut (
        .clk          (clk),
        .rst          (rst),
        .init_data    (init_data),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sync_event   (sync_event),
        .init_done    (init_done),
        .overflow_cnt (overflow_cnt)
    );

    pcileech_com_rxpack #(
        .RATIO    (4),
        .INIT_CNT (0)
    ) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .init_data    (init_data4),
        .in_data      (in_data4),
        .in_valid     (in_valid4),
        .out_data     (out_data4),
        .out_valid    (out_valid4),
        .out_ready    (out_ready4),
        .sync_event   (sync_event4),
        .init_done    (init_done4),
        .overflow_cnt (overflow_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Boot sequence after reset release, with out_ready high and no input.
    task automatic run_boot(input string tag);
        logic        ev;
        logic [63:0] ed;
        for (int n = 1; n <= 21; n++) begin
            tick();
            ev = (n >= 16 && n <= 20);
            ed = ev ? 64'(n - 15) : 64'd0;
            checks++;
            if (out_valid !== ev) begin
                errors++;
                $display("FAIL %s_valid cycle %0d: got %0b want %0b", tag, n, out_valid, ev);
            end
            checks++;
            if (out_data !== ed) begin
                errors++;
                $display("FAIL %s_data cycle %0d: got %h want %h", tag, n, out_data, ed);
            end
            checks++;
            if (init_done !== (n == 21)) begin
                errors++;
                $display("FAIL %s_init_done cycle %0d: got %0b want %0b", tag, n, init_done, (n == 21));
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        rst4       = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b0;
        init_data  = {64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
        init_data4 = '0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++;
        if (sync_event !== 1'b0) begin errors++; $display("FAIL reset_sync_event: got %0b want 0", sync_event); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %0b want 0", init_done); end
        checks++;
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_overflow_cnt: got %0d want 0", overflow_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_boot();
        run_boot("boot");
    endtask

    task automatic test_packing();
        in_valid = 1'b1;
        in_data  = 32'hAAAA0001;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pack_lane0_valid: got %0b want 0", out_valid); end
        in_data = 32'h0000BBBB;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pack_valid: got %0b want 1", out_valid); end
        checks++;
        if (out_data !== 64'hAAAA0001_0000BBBB) begin
            errors++;
            $display("FAIL pack_data: got %h want %h", out_data, 64'hAAAA0001_0000BBBB);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pack_drain_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_resync();
        logic [31:0] din [11];
        logic        vin [11];
        logic        ev  [11];
        logic [63:0] ed  [11];
        logic        es  [11];
        din = '{32'h11111111, 32'h66665555, 32'h66665555, 32'h22222222, 32'h33333333, 32'h0,
                32'h66665555, 32'h66665555, 32'h44444444, 32'h55555555, 32'h0};
        vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ev  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ed  = '{64'h0, 64'h11111111_66665555, 64'h0, 64'h0, 64'h22222222_33333333, 64'h0,
                64'h0, 64'h0, 64'h0, 64'h44444444_55555555, 64'h0};
        es  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = vin[i];
            in_data  = din[i];
            tick();
            checks++;
            if (sync_event !== es[i]) begin
                errors++;
                $display("FAIL resync_event step %0d: got %0b want %0b", i, sync_event, es[i]);
            end
            checks++;
            if (out_valid !== ev[i]) begin
                errors++;
                $display("FAIL resync_valid step %0d: got %0b want %0b", i, out_valid, ev[i]);
            end
            checks++;
            if (out_data !== ed[i]) begin
                errors++;
                $display("FAIL resync_data step %0d: got %h want %h", i, out_data, ed[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] p1;
        logic [63:0] pk;
        p1 = {32'd1, 32'd2};
        out_ready = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            in_valid = (t <= 12);
            in_data  = 32'(t);
            tick();
            checks++;
            if (out_valid !== (t >= 2)) begin
                errors++;
                $display("FAIL bp_stall_valid cycle %0d: got %0b want %0b", t, out_valid, (t >= 2));
            end
            if (t >= 2) begin
                checks++;
                if (out_data !== p1) begin
                    errors++;
                    $display("FAIL bp_stall_data cycle %0d: got %h want %h", t, out_data, p1);
                end
            end
            if (t == 10) begin
                checks++;
                if (overflow_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL bp_overflow_mid: got %0d want 1", overflow_cnt);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (overflow_cnt !== 16'd2) begin errors++; $display("FAIL bp_overflow: got %0d want 2", overflow_cnt); end
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            pk = {32'(2*k - 1), 32'(2*k)};
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid word %0d: got %0b want 1", k, out_valid); end
            checks++;
            if (out_data !== pk) begin errors++; $display("FAIL bp_drain_data word %0d: got %h want %h", k, out_data, pk); end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(i);
            tick();
        end
        checks++;
        if (out_data !== {32'hC0, 32'hC1}) begin
            errors++;
            $display("FAIL rmid_pre_data: got %h want %h", out_data, {32'hC0, 32'hC1});
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_data !== 64'd0) begin errors++; $display("FAIL rmid_data: got %h want 0", out_data); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL rmid_init_done: got %0b want 0", init_done); end
        checks++;
        if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL rmid_overflow: got %0d want 0", overflow_cnt); end
        checks++;
        if (sync_event !== 1'b0) begin errors++; $display("FAIL rmid_sync: got %0b want 0", sync_event); end
        rst       = 1'b0;
        out_ready = 1'b1;
        run_boot("rmid_boot");
        // Partial lane must be gone: first new word starts a fresh pair.
        in_valid = 1'b1;
        in_data  = 32'hD1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lane_valid: got %0b want 0", out_valid); end
        in_data = 32'hD2;
        tick();
        checks++;
        if (out_data !== {32'hD1, 32'hD2}) begin
            errors++;
            $display("FAIL rmid_fresh_data: got %h want %h", out_data, {32'hD1, 32'hD2});
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %0b want 0", out_valid); end
    endtask

    task automatic test_width();
        logic [127:0] exp4;
        exp4 = {32'd1, 32'd2, 32'd3, 32'd4};
        rst4 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (init_done4 !== (n == 16)) begin
                errors++;
                $display("FAIL w4_init_done cycle %0d: got %0b want %0b", n, init_done4, (n == 16));
            end
            checks++;
            if (out_valid4 !== 1'b0) begin errors++; $display("FAIL w4_boot_valid cycle %0d: got %0b want 0", n, out_valid4); end
        end
        out_ready4 = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            in_valid4 = 1'b1;
            in_data4  = 32'(w);
            tick();
            checks++;
            if (out_valid4 !== (w == 4)) begin
                errors++;
                $display("FAIL w4_valid lane %0d: got %0b want %0b", w, out_valid4, (w == 4));
            end
        end
        checks++;
        if (out_data4 !== exp4) begin errors++; $display("FAIL w4_data: got %h want %h", out_data4, exp4); end
        in_valid4 = 1'b0;
        tick();
        checks++;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL w4_drain: got %0b want 0", out_valid4); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_packing();
        test_resync();
        test_backpressure();
        test_reset_mid();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
